// File: rtl/chacha_stream_xor.sv
// ChaCha keystream consumer: requests 512-bit blocks and XORs them lane by lane into a 128-bit stream.
// Optional macro CHACHA_XOR_PREFETCH_EN adds a second block buffer that is refilled ahead of use.
module chacha_stream_xor (
    input  logic         clk,
    input  logic         rst,
    output logic         ks_req,
    input  logic         ks_valid,
    input  logic [511:0] ks_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic [31:0]  blk_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_REQ, S_FULL} state_e;

    state_e        state_q, state_d;
    logic          ks_req_q, ks_req_d;
    logic [511:0]  ks_buf_q, ks_buf_d;
    logic [1:0]    lane_idx_q, lane_idx_d;
    logic [31:0]   blk_cnt_q, blk_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic capture;
    logic accept;
    logic exhaust;
    logic refill;

`ifdef CHACHA_XOR_PREFETCH_EN
    logic [511:0]  ks_nxt_q, ks_nxt_d;
    logic          nxt_vld_q, nxt_vld_d;
`endif

    // A returning block only counts while a request is outstanding; stray pulses are dropped.
    assign capture  = ks_valid && ks_req_q;
    assign in_ready = (state_q == S_FULL) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign exhaust  = accept && ((lane_idx_q == 2'd3) || in_last);

`ifdef CHACHA_XOR_PREFETCH_EN
    assign refill = exhaust && (nxt_vld_q || capture);
`else
    assign refill = 1'b0;
`endif

    // NOTE: every signal driven in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: if (in_valid) state_d = S_REQ;
            S_REQ:   if (capture) state_d = S_FULL;
            S_FULL: begin
                if (exhaust) begin
                    if (refill)        state_d = S_FULL;
                    else if (ks_req_q) state_d = S_REQ;
                    else               state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        ks_buf_d    = ks_buf_q;
        lane_idx_d  = lane_idx_q;
        blk_cnt_d   = blk_cnt_q + {31'd0, capture};
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (capture && (state_q == S_REQ)) begin
            ks_buf_d   = ks_data;
            lane_idx_d = 2'd0;
        end

        if (accept) begin
            out_data_d  = in_data ^ ks_buf_q[{lane_idx_q, 7'd0} +: 128];
            out_last_d  = in_last;
            out_valid_d = 1'b1;
            lane_idx_d  = exhaust ? 2'd0 : lane_idx_q + 2'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef CHACHA_XOR_PREFETCH_EN
        ks_nxt_d  = ks_nxt_q;
        nxt_vld_d = nxt_vld_q;
        if (capture && (state_q == S_FULL)) begin
            if (exhaust) begin
                ks_buf_d = ks_data;
            end else begin
                ks_nxt_d  = ks_data;
                nxt_vld_d = 1'b1;
            end
        end else if (exhaust && nxt_vld_q) begin
            ks_buf_d  = ks_nxt_q;
            nxt_vld_d = 1'b0;
        end
        // The request always drops for a cycle after a capture, so at most one is in flight.
        if (ks_req_q)
            ks_req_d = !capture;
        else
            ks_req_d = (state_d == S_REQ) || ((state_d == S_FULL) && !nxt_vld_d);
`else
        ks_req_d = (state_d == S_REQ);
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the wide keystream buffers are reset too, so no stale key material survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            ks_req_q    <= 1'b0;
            ks_buf_q    <= '0;
            lane_idx_q  <= 2'd0;
            blk_cnt_q   <= 32'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef CHACHA_XOR_PREFETCH_EN
            ks_nxt_q    <= '0;
            nxt_vld_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ks_req_q    <= ks_req_d;
            ks_buf_q    <= ks_buf_d;
            lane_idx_q  <= lane_idx_d;
            blk_cnt_q   <= blk_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef CHACHA_XOR_PREFETCH_EN
            ks_nxt_q    <= ks_nxt_d;
            nxt_vld_q   <= nxt_vld_d;
`endif
        end
    end

    assign ks_req    = ks_req_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor: behavioural keystream generator, output monitor, hand-computed vectors.
// Build with CHACHA_XOR_PREFETCH_EN defined to exercise the prefetch variant instead of the lazy one.
module tb_chacha_stream_xor;

    logic         clk = 1'b0;
    logic         rst;
    logic         ks_req;
    logic         ks_valid = 1'b0;
    logic [511:0] ks_data  = '0;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic [31:0]  blk_cnt;

    always #5 clk = ~clk;

    chacha_stream_xor dut (
        .clk       (clk),
        .rst       (rst),
        .ks_req    (ks_req),
        .ks_valid  (ks_valid),
        .ks_data   (ks_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] lane_of(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [511:0] block_of(input logic [7:0] base);
        return {lane_of(base + 8'd3), lane_of(base + 8'd2), lane_of(base + 8'd1), lane_of(base)};
    endfunction

    // Keystream generator: answers a request gen_lat+1 cycles after seeing it, one-cycle pulse.
    logic [511:0] blk [0:15];
    int           gen_lat   = 0;
    int           gen_idx   = 0;
    bit           busy      = 1'b0;
    int           cnt       = 0;
    int           spur_req  = 0;
    int           spur_done = 0;
    logic [511:0] spur_data = '0;
    int           rises     = 0;
    int           pulses    = 0;
    logic         req_prev  = 1'b0;
    logic         req_after_pulse = 1'b1;
    int           gcyc      = 0;
    int           rise_cyc  [0:15];
    int           pulse_cyc [0:15];

    always @(posedge clk) begin
        #1;
        gcyc++;
        if (ks_valid) req_after_pulse = ks_req;
        if (ks_req && !req_prev) begin
            rise_cyc[rises % 16] = gcyc;
            rises++;
        end
        req_prev = ks_req;
        ks_valid = 1'b0;
        if (spur_req != spur_done) begin
            spur_done++;
            ks_valid = 1'b1;
            ks_data  = spur_data;
        end else if (busy) begin
            if (cnt == 0) begin
                ks_valid = 1'b1;
                ks_data  = blk[gen_idx];
                gen_idx  = (gen_idx + 1) % 16;
                busy     = 1'b0;
                pulse_cyc[pulses % 16] = gcyc;
                pulses++;
            end else begin
                cnt--;
            end
        end else if (ks_req) begin
            busy = 1'b1;
            cnt  = gen_lat;
        end
    end

    // Output monitor: records every beat handed downstream and the cycle of every accepted input.
    logic [127:0] obs_data [0:63];
    logic         obs_last [0:63];
    int           obs_n = 0;
    int           mcyc  = 0;
    int           acc_cyc [0:63];
    int           acc_n = 0;

    always @(negedge clk) begin
        mcyc++;
        if (!rst && out_valid && out_ready && obs_n < 64) begin
            obs_data[obs_n] = out_data;
            obs_last[obs_n] = out_last;
            obs_n++;
        end
        if (!rst && in_valid && in_ready && acc_n < 64) begin
            acc_cyc[acc_n] = mcyc;
            acc_n++;
        end
    end

    int rd = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [127:0] d, input logic l);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 128'(done), 128'(1'b1));
    endtask

    task automatic expect_beat(input string tag, input logic [127:0] d, input logic l);
        if (rd < obs_n) begin
            check({tag, "_data"}, obs_data[rd], d);
            check({tag, "_last"}, 128'(obs_last[rd]), 128'(l));
            rd++;
        end else begin
            check({tag, "_missing"}, 128'(obs_n), 128'(rd + 1));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ks_req"},    128'(ks_req),    128'(1'b0));
        check({tag, "_in_ready"},  128'(in_ready),  128'(1'b0));
        check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_out_last"},  128'(out_last),  128'(1'b0));
        check({tag, "_out_data"},  out_data,        128'd0);
        check({tag, "_blk_cnt"},   128'(blk_cnt),   128'd0);
    endtask

    localparam logic [127:0] PAT = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        logic [127:0] g0, g1;
        logic [127:0] d [0:3];
        int           r0, p0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;

`ifdef CHACHA_XOR_PREFETCH_EN
        blk[0] = block_of(8'h10);
        blk[1] = block_of(8'h20);
        blk[2] = block_of(8'h30);
        blk[3] = block_of(8'h40);
        gen_lat = 19;
`else
        blk[0] = block_of(8'h10);
        blk[1] = '1;
        blk[2] = '1;
        blk[3] = block_of(8'h20);
        blk[4] = block_of(8'h10);
        blk[5] = block_of(8'h20);
        blk[6] = block_of(8'h10);
        blk[7] = block_of(8'h20);
`endif

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_state("reset");

`ifdef CHACHA_XOR_PREFETCH_EN
        // Three beats, then idle long enough for the prefetched block to land.
        for (int i = 0; i < 3; i++) send_beat('0, 1'b0);
        repeat (30) tick();
        check("pf_second_req", 128'(rise_cyc[1] - pulse_cyc[0]), 128'd2);
        check("pf_blk_cnt_prefetched", 128'(blk_cnt), 128'd2);
        for (int i = 3; i < 8; i++) send_beat('0, 1'b0);
        check("pf_no_bubble", 128'(acc_cyc[4] - acc_cyc[3]), 128'd1);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) expect_beat("pf_blk1", lane_of(8'h10 + 8'(k)), 1'b0);
        for (int k = 0; k < 4; k++) expect_beat("pf_blk2", lane_of(8'h20 + 8'(k)), 1'b0);
        check("pf_blk_cnt_after8", 128'(blk_cnt), 128'd2);
        repeat (26) tick();
        check("pf_blk_cnt_third", 128'(blk_cnt), 128'd3);
`else
        // Lane order: zero plaintext exposes the keystream lanes directly.
        for (int i = 0; i < 4; i++) send_beat('0, 1'b0);
        repeat (3) tick();
        for (int k = 0; k < 4; k++) expect_beat("lane", lane_of(8'h10 + 8'(k)), 1'b0);
        check("lane_blk_cnt", 128'(blk_cnt), 128'd1);
        check("lane_req_drop", 128'(req_after_pulse), 128'(1'b0));
        check("lane_idle_req", 128'(ks_req), 128'(1'b0));

        // Involution with an all-ones keystream, then the outputs fed back.
        send_beat(PAT, 1'b0);
        send_beat(~PAT, 1'b1);
        repeat (3) tick();
        g0 = obs_data[rd];
        g1 = obs_data[rd + 1];
        expect_beat("inv_fwd0", ~PAT, 1'b0);
        expect_beat("inv_fwd1", PAT, 1'b1);
        send_beat(g0, 1'b0);
        send_beat(g1, 1'b1);
        repeat (3) tick();
        expect_beat("inv_back0", PAT, 1'b0);
        expect_beat("inv_back1", ~PAT, 1'b1);
        check("inv_blk_cnt", 128'(blk_cnt), 128'd3);

        // Early last: the next message must start on lane 0 of a fresh block.
        r0 = rises;
        send_beat(128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0);
        send_beat(128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 1'b1);
        send_beat(128'h00000000_00000000_00000000_000000FF, 1'b1);
        repeat (3) tick();
        expect_beat("early0", 128'hDEADBEEF_00000000_CAFEF00D_12345678 ^ lane_of(8'h20), 1'b0);
        expect_beat("early1", 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA ^ lane_of(8'h21), 1'b1);
        expect_beat("early2", 128'h00000000_00000000_00000000_000000FF ^ lane_of(8'h10), 1'b1);
        check("early_blk_cnt", 128'(blk_cnt), 128'd5);
        check("early_req_rises", 128'(rises - r0), 128'd2);

        // Backpressure mid-block: output holds, input stalls, nothing lost or duplicated.
        for (int i = 0; i < 4; i++) d[i] = {4{32'h1111_0000 + 32'(i)}};
        send_beat(d[0], 1'b0);
        send_beat(d[1], 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d[2];
        in_last   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
            check("bp_out_valid", 128'(out_valid), 128'(1'b1));
            check("bp_out_data", out_data, d[1] ^ lane_of(8'h21));
            tick();
        end
        out_ready = 1'b1;
        send_beat(d[2], 1'b0);
        send_beat(d[3], 1'b1);
        repeat (3) tick();
        for (int k = 0; k < 4; k++) expect_beat("bp", d[k] ^ lane_of(8'h20 + 8'(k)), k == 3);
        check("bp_no_extra", 128'(obs_n), 128'(rd));

        // Spurious ks_valid while empty is ignored.
        spur_data = {4{128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A}};
        spur_req++;
        repeat (4) tick();
        check("spur_blk_cnt", 128'(blk_cnt), 128'd6);
        check("spur_ks_req", 128'(ks_req), 128'(1'b0));
        check("spur_in_ready", 128'(in_ready), 128'(1'b0));
        send_beat(128'h00000000_00000000_00000000_000000FF, 1'b1);
        repeat (3) tick();
        expect_beat("spur_next", 128'h00000000_00000000_00000000_000000FF ^ lane_of(8'h10), 1'b1);
        check("spur_next_blk_cnt", 128'(blk_cnt), 128'd7);

        // Reset while a request is outstanding; the late reply must be ignored.
        gen_lat  = 10;
        p0       = pulses;
        in_valid = 1'b1;
        in_data  = PAT;
        in_last  = 1'b1;
        repeat (3) tick();
        check("rst_req_pending", 128'(ks_req), 128'(1'b1));
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (15) tick();
        check("rst_late_pulse_sent", 128'(pulses - p0), 128'd1);
        check_reset_state("rst_mid");
        check("rst_no_beat", 128'(obs_n), 128'(rd));
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
